// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq
//
// Multi-cycle forward AES SubBytes engine. A 128-bit state is loaded into a
// working register and pushed through LANES S-box lanes per cycle. Each cycle
// the register is rotated left by LANES bytes, so after N = 16/LANES cycles
// every byte has been substituted once and is back in its original position.
//
// Optional feature macro: SUBBYTES_INV_MODE_EN
//   When defined, an 'inv' input and a parallel inverse S-box per lane are
//   added. The lane mux is steered by a mode flop captured at acceptance.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   state_in holds a block to process
//   in_ready   engine can accept a block (IDLE)
//   state_in   input state, byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  state_out holds a completed result (HOLD)
//   out_ready  downstream accepts the result
//   state_out  substituted state, same byte order as state_in
//   inv        (SUBBYTES_INV_MODE_EN only) select inverse S-box
// -----------------------------------------------------------------------------
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SUBBYTES_INV_MODE_EN
  input  logic         inv,
`endif
  output logic [127:0] state_out
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUBBYTES_INV_MODE_EN
  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
`endif

  // Entry x sits at bit 2047 - 8*x, which in 11 bits is simply {~x, 3'b111}.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    return SBOX_FWD[{~x, 3'b111} -: 8];
  endfunction

`ifdef SUBBYTES_INV_MODE_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    return SBOX_INV[{~x, 3'b111} -: 8];
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [127:0]         w_q;
  logic [127:0]         w_rot;
  logic [CW-1:0]        cnt_q;
  logic [8*LANES-1:0]   sub_bytes;
  logic                 load;
  logic                 step;
`ifdef SUBBYTES_INV_MODE_EN
  logic                 mode_q;
`endif

  // S-box lanes: lane i handles byte i of the top slice, keeping byte order.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] lane_in;
    assign lane_in = w_q[127-8*i -: 8];
`ifdef SUBBYTES_INV_MODE_EN
    assign sub_bytes[8*LANES-1-8*i -: 8] = mode_q ? sbox_inv(lane_in) : sbox_fwd(lane_in);
`else
    assign sub_bytes[8*LANES-1-8*i -: 8] = sbox_fwd(lane_in);
`endif
  end

  // Rotate-left by LANES bytes with the substituted bytes entering at the
  // bottom; with 16 lanes the whole register is replaced in one step.
  if (LANES == 16) begin : g_rot_full
    assign w_rot = sub_bytes;
  end else begin : g_rot_part
    assign w_rot = {w_q[127-8*LANES:0], sub_bytes};
  end

  // Next-state decode; load/step steer the datapath register.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
`ifdef SUBBYTES_INV_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        w_q    <= state_in;
        cnt_q  <= '0;
`ifdef SUBBYTES_INV_MODE_EN
        mode_q <= inv;
`endif
      end else if (step) begin
        w_q   <= w_rot;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Handshake outputs are pure decodes of the registered state.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign state_out = w_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_seq
//
// Directed self-checking bench for sub_bytes_seq. The main instance uses the
// default LANES=4; four extra instances cover LANES=1, 2, 8 and 16.
// Define SUBBYTES_INV_MODE_EN to also exercise the inverse mode.
// -----------------------------------------------------------------------------
module tb_sub_bytes_seq;

  localparam logic [127:0] VEC_A   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP_A   = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] VEC_B   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] EXP_B   = 128'h7c266e85a762bddfbb86f446382023ca;
  localparam logic [127:0] EXP_ZERO = {16{8'h63}};

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
`ifdef SUBBYTES_INV_MODE_EN
  logic         inv;
`endif

  int checks;
  int errors;

  sub_bytes_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SUBBYTES_INV_MODE_EN
    .inv       (inv),
`endif
    .state_out (state_out)
  );

  // Extra instances with other lane counts, all fed zeros and out_ready=1.
  logic         lv_in_valid  [4];
  logic         lv_in_ready  [4];
  logic         lv_out_valid [4];
  logic [127:0] lv_state_out [4];
  logic [127:0] lv_state_in;
  logic         lv_out_ready;

  for (genvar g = 0; g < 4; g++) begin : g_lanes
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    sub_bytes_seq #(.LANES(L)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (lv_in_valid[g]),
      .in_ready  (lv_in_ready[g]),
      .state_in  (lv_state_in),
      .out_valid (lv_out_valid[g]),
      .out_ready (lv_out_ready),
`ifdef SUBBYTES_INV_MODE_EN
      .inv       (1'b0),
`endif
      .state_out (lv_state_out[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one block for one edge; caller guarantees in_ready is high.
  task automatic applyStimulus(input logic [127:0] data);
    state_in = data;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid, bounded so a stuck DUT still finishes.
  task automatic waitOutput(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int           lat;
    int           acc [$];
    logic [127:0] res [$];
    logic         accept_now;
    logic         take_now;
    logic         seen;
    int           xn [4] = '{16, 8, 2, 1};

    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    state_in     = '0;
    lv_state_in  = '0;
    lv_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) lv_in_valid[k] = 1'b0;
`ifdef SUBBYTES_INV_MODE_EN
    inv = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_state_out", state_out, '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Known vector, latency and return to IDLE
    out_ready = 1'b1;
    applyStimulus(VEC_A);
    waitOutput(lat);
    checkOutput("a_latency", lat, 4);
    checkOutput("a_data", state_out, EXP_A);
    checkOutput("a_in_ready_hold", in_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("a_out_valid_after", out_valid, 0);
    checkOutput("a_in_ready_after", in_ready, 1);

    // All-zero block under backpressure; a second request must be ignored
    out_ready = 1'b0;
    applyStimulus('0);
    waitOutput(lat);
    checkOutput("z_latency", lat, 4);
    checkOutput("z_data", state_out, EXP_ZERO);
    state_in = VEC_B;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", out_valid, 1);
      checkOutput("bp_data", state_out, EXP_ZERO);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("bp_single_xfer", out_valid, 0);
    checkOutput("bp_no_load", state_out, EXP_ZERO);

    // Back-to-back with in_valid held high
    state_in = VEC_A;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      accept_now = in_ready && in_valid;
      take_now   = out_valid && out_ready;
      if (take_now) res.push_back(state_out);
      @(posedge clk);
      #1;
      if (accept_now) begin
        acc.push_back(c);
        if (acc.size() == 1) state_in = VEC_B;
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_accepts", acc.size(), 2);
    checkOutput("b2b_spacing", (acc.size() >= 2) ? acc[1] - acc[0] : -1, 6);
    checkOutput("b2b_results", res.size(), 2);
    checkOutput("b2b_data0", (res.size() >= 1) ? res[0] : 'x, EXP_A);
    checkOutput("b2b_data1", (res.size() >= 2) ? res[1] : 'x, EXP_B);

`ifdef SUBBYTES_INV_MODE_EN
    // Inverse mode; inv toggled mid-run must not matter
    inv = 1'b1;
    applyStimulus(EXP_A);
    @(posedge clk);
    #1;
    inv = 1'b0;
    waitOutput(lat);
    checkOutput("inv_data", state_out, VEC_A);
    @(posedge clk);
    #1;
`endif

    // Other lane counts: same result, latency 16/LANES
    for (int k = 0; k < 4; k++) begin
      lv_in_valid[k] = 1'b1;
      @(posedge clk);
      #1;
      lv_in_valid[k] = 1'b0;
      lat = 0;
      while (!lv_out_valid[k] && lat < 40) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checkOutput($sformatf("lanes%0d_latency", 16 / xn[k]), lat, xn[k]);
      checkOutput($sformatf("lanes%0d_data", 16 / xn[k]), lv_state_out[k], EXP_ZERO);
      @(posedge clk);
      #1;
    end

    // Reset pulsed mid-run at cnt == 2
    applyStimulus(VEC_A);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_state_out", state_out, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    checkOutput("post_rst_no_output", seen, 0);
    checkOutput("post_rst_in_ready", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
